// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM state encoding, byte width, idle fill byte.
package spi_target_pkg;

  localparam int         BYTE_BITS = 8;
  localparam logic [7:0] IDLE_FILL = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for one asynchronous input; RESET_VAL is the input's idle level.
module spi_target_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with one-byte TX holding buffer and one-byte RX register.
// Define SPI_TARGET_DC_EN to capture the spi_dc line alongside each received byte.
module spi_target
  import spi_target_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       rx_overrun,
  output logic       tx_underrun,
  input  logic       status_clear,
  output logic       txn_end
);

  logic cs_s, sck_s, mosi_s;

  spi_target_sync #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rstn(rstn), .d(spi_cs),   .q(cs_s));
  spi_target_sync #(.RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .rstn(rstn), .d(spi_sck),  .q(sck_s));
  spi_target_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rstn(rstn), .d(spi_mosi), .q(mosi_s));

`ifdef SPI_TARGET_DC_EN
  logic dc_s, dc_cap_q, rx_dc_q;
  spi_target_sync #(.RESET_VAL(1'b0)) u_sync_dc (.clk(clk), .rstn(rstn), .d(spi_dc), .q(dc_s));
  assign rx_dc = rx_dc_q;
`else
  logic unused_dc;
  assign unused_dc = spi_dc;
  assign rx_dc     = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        sck_prev_q, cs_prev_q, armed_q;
  logic [1:0]  flush_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_shift_q, tx_shift_q, hold_q, rx_data_q;
  logic        hold_full_q, byte_done_q, reload_q;
  logic        rx_valid_q, rx_overrun_q, tx_underrun_q, txn_end_q;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic active, enter, leave, consume;
  logic [7:0] next_tx;

  // A CS fall only counts once CS has been seen high after reset, so a select
  // held low across reset cannot start a transfer.
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign active   = (state_q == ACTIVE);
  assign enter    = (state_q == IDLE) & cs_fall;
  assign leave    = active & cs_rise;
  assign consume  = enter | (active & sck_fall & reload_q);
  assign next_tx  = hold_full_q ? hold_q : IDLE_FILL;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_q    <= 2'b00;
      armed_q    <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      flush_q    <= {flush_q[0], 1'b1};
      armed_q    <= armed_q | (flush_q[1] & cs_s);
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_miso    = 1'b1;
    spi_miso_oe = 1'b0;
    if (state_q == ACTIVE) begin
      spi_miso    = tx_shift_q[7];
      spi_miso_oe = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= IDLE_FILL;
      byte_done_q <= 1'b0;
      reload_q    <= 1'b0;
      txn_end_q   <= 1'b0;
`ifdef SPI_TARGET_DC_EN
      dc_cap_q    <= 1'b0;
`endif
    end else begin
      byte_done_q <= 1'b0;
      txn_end_q   <= leave;
      if (enter) begin
        bit_cnt_q  <= '0;
        reload_q   <= 1'b0;
        tx_shift_q <= next_tx;
      end else if (leave) begin
        bit_cnt_q <= '0;
        reload_q  <= 1'b0;
      end else if (active) begin
        if (sck_rise) begin
          rx_shift_q <= {rx_shift_q[6:0], mosi_s};
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
            byte_done_q <= 1'b1;
            reload_q    <= 1'b1;
`ifdef SPI_TARGET_DC_EN
            dc_cap_q    <= dc_s;
`endif
          end
        end
        if (sck_fall) begin
          if (reload_q) begin
            tx_shift_q <= next_tx;
            reload_q   <= 1'b0;
          end else begin
            tx_shift_q <= {tx_shift_q[6:0], 1'b1};
          end
        end
      end
    end
  end

  // Holding buffer: a load in the same cycle as a consume attempt is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      if (consume)                    hold_full_q <= 1'b0;
      else if (tx_load & ~hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      if (consume & ~hold_full_q) tx_underrun_q <= 1'b1;
      else if (status_clear)      tx_underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef SPI_TARGET_DC_EN
      rx_dc_q      <= 1'b0;
`endif
    end else begin
      if (byte_done_q & (~rx_valid_q | rx_read)) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
`ifdef SPI_TARGET_DC_EN
        rx_dc_q    <= dc_cap_q;
`endif
      end else if (rx_read) begin
        rx_valid_q <= 1'b0;
      end
      if (byte_done_q & rx_valid_q & ~rx_read) rx_overrun_q <= 1'b1;
      else if (status_clear)                   rx_overrun_q <= 1'b0;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign txn_end     = txn_end_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target; SCK runs at clk/8, inputs change on clk falling edges.
module tb_spi_target;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       spi_cs = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic       rx_dc, rx_valid, rx_read = 1'b0, rx_overrun, tx_underrun;
  logic       status_clear = 1'b0, txn_end;

  int tests = 0;
  int fails = 0;
  int txn_cnt = 0;

  spi_target dut (
    .clk(clk), .rstn(rstn), .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .status_clear(status_clear),
    .txn_end(txn_end)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (txn_end === 1'b1) txn_cnt++;

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    clks(8);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    clks(8);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      clks(4);
      mi = {mi[6:0], spi_miso};
      spi_sck = 1'b1;
      clks(4);
      spi_sck = 1'b0;
    end
    clks(4);
  endtask

  task automatic do_load(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1; clks(1); tx_load = 1'b0;
  endtask

  task automatic do_read();
    rx_read = 1'b1; clks(1); rx_read = 1'b0;
  endtask

  task automatic do_clear();
    status_clear = 1'b1; clks(1); status_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    clks(2);
    got = {spi_miso, spi_miso_oe, tx_ready, rx_data, rx_dc, rx_valid, rx_overrun, tx_underrun, txn_end};
    tests++;
    if (got !== 16'hA000) begin fails++; $display("FAIL reset_outputs got %h exp %h", got, 16'hA000); end
    rstn = 1'b1;
    clks(5);
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    int t0;
    t0 = txn_cnt;
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_before got %b exp 1", tx_ready); end
    do_load(8'hA5);
    tests++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_loaded got %b exp 0", tx_ready); end
    cs_low();
    tests++;
    if (spi_miso_oe !== 1'b1) begin fails++; $display("FAIL basic_oe_active got %b exp 1", spi_miso_oe); end
    xfer(8'h3C, 8, mi);
    cs_high();
    tests++;
    if (mi !== 8'hA5) begin fails++; $display("FAIL basic_miso got %h exp a5", mi); end
    tests++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      fails++; $display("FAIL basic_rx got %h/%b exp 3c/1", rx_data, rx_valid);
    end
    tests++;
    if (txn_cnt - t0 != 1) begin fails++; $display("FAIL basic_txn_end got %0d pulses exp 1", txn_cnt - t0); end
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after got %b exp 1", tx_ready); end
    do_read();
    tests++;
    if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_read_clears got %b exp 0", rx_valid); end
    do_read();
    tests++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h3C) begin
      fails++; $display("FAIL basic_read_idle got %h/%b exp 3c/0", rx_data, rx_valid);
    end
    do_clear();
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    cs_low();
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    cs_high();
    tests++;
    if (rx_data !== 8'h11 || rx_valid !== 1'b1 || rx_overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_set got %h/%b/%b exp 11/1/1", rx_data, rx_valid, rx_overrun);
    end
    do_clear();
    tests++;
    if (rx_overrun !== 1'b0 || rx_valid !== 1'b1) begin
      fails++; $display("FAIL overrun_clear got %b/%b exp 0/1", rx_overrun, rx_valid);
    end
    do_read();
    do_clear();
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    tests++;
    if (tx_underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear got %b exp 0", tx_underrun); end
    cs_low();
    xfer(8'h00, 8, mi);
    tests++;
    if (mi !== 8'hFF || tx_underrun !== 1'b1) begin
      fails++; $display("FAIL underrun_fill got %h/%b exp ff/1", mi, tx_underrun);
    end
    cs_high();
    do_read();
    do_clear();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int t0;
    t0 = txn_cnt;
    cs_low();
    xfer(8'hFF, 5, mi);
    cs_high();
    tests++;
    if (rx_valid !== 1'b0 || txn_cnt - t0 != 1) begin
      fails++; $display("FAIL abort_partial got valid %b pulses %0d exp 0/1", rx_valid, txn_cnt - t0);
    end
    cs_low();
    xfer(8'h81, 8, mi);
    cs_high();
    tests++;
    if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin
      fails++; $display("FAIL abort_next_byte got %h/%b exp 81/1", rx_data, rx_valid);
    end
    do_read();
    do_clear();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    do_load(8'hA5);
    cs_low();
    tests++;
    if (tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_entry_consume got %b exp 1", tx_ready); end
    do_load(8'hC3);
    do_load(8'h77);
    tests++;
    if (tx_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full got %b exp 0", tx_ready); end
    xfer(8'h01, 8, mi1);
    xfer(8'h02, 8, mi2);
    cs_high();
    tests++;
    if (mi1 !== 8'hA5 || mi2 !== 8'hC3) begin
      fails++; $display("FAIL b2b_miso got %h %h exp a5 c3", mi1, mi2);
    end
    tests++;
    if (rx_data !== 8'h01 || rx_overrun !== 1'b1) begin
      fails++; $display("FAIL b2b_rx got %h/%b exp 01/1", rx_data, rx_overrun);
    end
    do_read();
    do_clear();
  endtask

  task automatic test_dc();
    logic [7:0] mi;
    logic       exp_dc;
`ifdef SPI_TARGET_DC_EN
    exp_dc = 1'b1;
`else
    exp_dc = 1'b0;
`endif
    spi_dc = 1'b1;
    cs_low();
    xfer(8'h5A, 8, mi);
    cs_high();
    spi_dc = 1'b0;
    tests++;
    if (rx_data !== 8'h5A || rx_dc !== exp_dc) begin
      fails++; $display("FAIL dc_capture got %h/%b exp 5a/%b", rx_data, rx_dc, exp_dc);
    end
    do_read();
    do_clear();
  endtask

  task automatic test_reset_midxfer();
    logic [7:0]  mi;
    logic [15:0] got;
    cs_low();
    xfer(8'h3C, 8, mi);
    do_load(8'h96);
    xfer(8'hFF, 3, mi);
    #1 rstn = 1'b0;
    #1;
    got = {spi_miso, spi_miso_oe, tx_ready, rx_data, rx_dc, rx_valid, rx_overrun, tx_underrun, txn_end};
    tests++;
    if (got !== 16'hA000) begin fails++; $display("FAIL midxfer_reset got %h exp %h", got, 16'hA000); end
    clks(2);
    rstn = 1'b1;
    clks(4);
    xfer(8'hFF, 8, mi);
    tests++;
    if (rx_valid !== 1'b0 || mi !== 8'hFF || spi_miso_oe !== 1'b0) begin
      fails++; $display("FAIL midxfer_held_cs got valid %b miso %h oe %b exp 0/ff/0", rx_valid, mi, spi_miso_oe);
    end
    cs_high();
    xfer(8'hAA, 8, mi);
    tests++;
    if (rx_valid !== 1'b0 || spi_miso_oe !== 1'b0) begin
      fails++; $display("FAIL midxfer_sck_idle got valid %b oe %b exp 0/0", rx_valid, spi_miso_oe);
    end
    cs_low();
    xfer(8'hC3, 8, mi);
    cs_high();
    tests++;
    if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin
      fails++; $display("FAIL midxfer_recover got %h/%b exp c3/1", rx_data, rx_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_overrun();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_dc();
    test_reset_midxfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rstn  input  1  asynchronous, active-low reset.
REQ-003 spi_cs  input  1  target select from remote controller, active-low, asynchronous to clk.
REQ-004 spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 spi_mosi  input  1  controller-to-target serial data, MSB first.
REQ-006 spi_dc  input  1  data/command line from controller; used only when SPI_TARGET_DC_EN is defined.
REQ-007 spi_miso  output  1  target-to-controller serial data, MSB first.
REQ-008 spi_miso_oe  output  1  MISO drive enable; high while select is active.
REQ-009 tx_data  input  8  next byte to transmit.
REQ-010 tx_load  input  1  one-cycle strobe that writes tx_data into the holding buffer.
REQ-011 tx_ready  output  1  holding buffer empty; tx_load is accepted only while high.
REQ-012 rx_data  output  8  last received byte.
REQ-013 rx_dc  output  1  DC level captured with rx_data.
REQ-014 rx_valid  output  1  rx_data holds an unread byte.
REQ-015 rx_read  input  1  one-cycle strobe that consumes rx_data and clears rx_valid.
REQ-016 rx_overrun  output  1  sticky flag: a byte was dropped.
REQ-017 tx_underrun  output  1  sticky flag: a byte started with the holding buffer empty.
REQ-018 status_clear  input  1  one-cycle strobe that clears both sticky flags.
REQ-019 txn_end  output  1  one-cycle pulse when select deasserts.

Function
REQ-020 Inputs spi_cs, spi_sck, spi_mosi and spi_dc SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized values.
REQ-021 Supported SCK: high and low phases each >= 4 clk periods; faster SCK is out of scope.
REQ-022 FSM states SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized CS falling edge, ACTIVE->IDLE on synchronized CS rising edge.
REQ-023 On entering ACTIVE: bit counter=0; TX shift register loads the holding buffer if it is full, else 8'hFF with tx_underrun set; tx_ready SHALL go high.
REQ-024 In ACTIVE, on each synchronized SCK rising edge: shift MOSI into the RX shift register LSB; bit counter increments modulo 8.
REQ-025 In ACTIVE, on each synchronized SCK falling edge: shift the TX register left by one; spi_miso SHALL show the new MSB.
REQ-026 On the 8th rising edge: a byte is complete; the TX register SHALL reload at the next falling edge using the REQ-023 rule.
REQ-027 Byte complete with rx_valid=0, or with rx_read in the same cycle: rx_data is updated and rx_valid=1 on the next cycle.
REQ-028 Byte complete with rx_valid=1 and no rx_read: the new byte is discarded, rx_data is unchanged, and rx_overrun is set.
REQ-029 tx_load while tx_ready=0 SHALL be ignored; tx_load in the same cycle as a buffer consume SHALL be ignored.
REQ-030 rx_read while rx_valid=0 SHALL have no effect.
REQ-031 status_clear concurrent with a set condition: set wins.
REQ-032 CS deassert mid-byte: partial bits discarded; rx_valid/rx_data unchanged; counter reset; txn_end pulses.
REQ-033 In IDLE: spi_miso=1, spi_miso_oe=0; SCK edges are ignored.
REQ-034 Latency, last SCK rising edge (pin) to rx_valid high: 4 clk cycles (2 sync + 1 edge detect + 1 register).

Reset
REQ-035 While rstn=0, all outputs SHALL be held at reset values: spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_dc=0, rx_valid=0, rx_overrun=0, tx_underrun=0, txn_end=0.
REQ-036 While rstn=0, FSM=IDLE, synchronizers=idle levels (cs=1, sck=0), and the buffer is empty.
REQ-037 Reset asserted mid-transfer SHALL abort the transfer; after release, a new CS falling edge is required before any data is accepted.

Configuration
REQ-038 With SPI_TARGET_DC_EN defined, rx_dc SHALL capture the synchronized spi_dc at the 8th rising edge and update alongside rx_data.
REQ-039 Without SPI_TARGET_DC_EN, rx_dc SHALL be constant 0, spi_dc unused, and its synchronizer omitted.

Structure
REQ-040 A shared package spi_target_pkg SHALL hold the state enum (IDLE, ACTIVE), BYTE_BITS=8 and IDLE_FILL=8'hFF.
REQ-041 A sub-module spi_target_sync (2-flop synchronizer, parameterised reset value) SHALL be instantiated per synchronized input.

Verification
REQ-042 tx_load 8'hA5, CS low, controller sends 8'h3C at SCK=clk/8, CS high -> MISO bits 10100101, rx_data=8'h3C, rx_valid=1, txn_end pulses once.
REQ-043 Two bytes 8'h11, 8'h22 sent, no rx_read -> rx_data=8'h11, rx_overrun=1; status_clear -> rx_overrun=0.
REQ-044 No tx_load, byte 8'h00 sent -> MISO all ones, tx_underrun=1.
REQ-045 CS high after 5 bits of 8'hFF -> rx_valid stays 0; next full byte 8'h81 received correctly.
REQ-046 DC_EN build, spi_dc=1 during byte 8'h5A -> rx_dc=1; non-DC build -> rx_dc=0.
REQ-047 rstn low after bit 3 -> all outputs at reset values at once; after release, SCK without CS low is ignored.
